seg7_bar_reader: RTL and testbench
==================================

Name: seg7_bar_reader

Overview:
- Receive-side counterpart to the bar-driving seven-segment controller.
- Samples the seven 24-bit RGB bar colours and thresholds each into a lit/unlit segment.
- Waits until the segment pattern is stable, then decodes it back to a hex digit.
- Checks that successive digits follow the controller's +1 mod 16 count sequence; sits beside the display in the world as a self-checking monitor.

Parameters:
- STABLE_CYCLES, 4: consecutive identical sampled patterns required before acceptance (>=1).
- LIT_THRESH, 8'h80: segment is lit if any 8-bit colour channel >= this value.
- ERR_CNT_W, 8: width of the saturating sequence-error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- bar_0..bar_6  in  24 each  RGB colour of segments a..g; bar_0=a, bar_6=g; channels [23:16],[15:8],[7:0].
- segs  out  7  last accepted stable pattern, bit i = bar_i lit.
- digit  out  4  last successfully decoded digit.
- digit_valid  out  1  one-cycle pulse when a valid digit is accepted.
- blank  out  1  level, high while the accepted pattern is all-unlit.
- pattern_err  out  1  one-cycle pulse when a non-hex, non-blank pattern is accepted.
- seq_err  out  1  one-cycle pulse when an accepted digit != previous+1 mod 16.
- seq_err_cnt  out  ERR_CNT_W  saturating count of seq_err pulses.

Behaviour:
- Reset values:
  - All outputs 0; internal seg_q, stability counter, has_prev and prev_digit cleared.
  - Async assert; deassert is sampled at the next clk edge.
- Stage 1 (registered):
  - seg_q[i] = (bar_i[23:16]>=T) | (bar_i[15:8]>=T) | (bar_i[7:0]>=T).
- Stability counter cnt, 0..STABLE_CYCLES, saturating:
  - If seg_q == seg_q_prev: cnt++ (saturating).
  - Otherwise cnt = 1 and the accepted flag is cleared.
- Accept:
  - Occurs on the edge where cnt becomes STABLE_CYCLES with the accepted flag clear; the flag is then set, giving exactly one accept per stable episode.
  - Latency: bars stable before edge k -> outputs update after edge k+STABLE_CYCLES.
- Decode table (hex of {g,f,e,d,c,b,a}):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Blank = 00.
- On accept:
  - segs <= pattern in all cases.
  - Valid digit: digit <= d; digit_valid pulse; blank <= 0.
    - If has_prev and d != prev_digit+1 mod 16: seq_err pulse and seq_err_cnt++ (holds at max).
    - prev_digit <= d; has_prev <= 1.
  - Blank: blank <= 1; has_prev <= 0; no pulses; digit holds.
  - Other: pattern_err pulse; has_prev <= 0; digit and blank hold.
- Simultaneous events:
  - A pattern change on the accept edge aborts acceptance.
  - All pulses are mutually consistent within one cycle: seq_err only accompanies digit_valid.
- Wrap-around: F -> 0 is legal, no error.
- Reset mid-settling: abandons the episode; after reset the first digit never flags seq_err.

Decomposition:
- Package seg7_pkg:
  - Segment index constants SEG_A..SEG_G.
  - 16 pattern constants SEG7_HEX[0..15].
  - SEG7_BLANK = 7'h00.
- Sub-module seg7_decode: combinational pattern[6:0] -> {valid, is_blank, digit[3:0]}, reusable by other display blocks.

Test Plan:
- Reset: assert rst with random bars -> all outputs 0.
- Threshold: bar_1 = bar_2 = 24'h00_7F_00 -> no lit segments.
  - Then set them to 24'h00_80_00, others 0, held 5 cycles -> digit_valid once, digit=1, segs=06.
- Count sweep: patterns 0..F then 0, each held 6 cycles -> 17 digit_valid pulses in order, seq_err_cnt=0.
- Glitch: 1-cycle pulse of pattern 7F inside a stable 3 (pattern 4F) -> no accept of 8; 3 re-accepted once after settle.
- Invalid pattern: 01 held 6 cycles -> single pattern_err, digit unchanged.
  - Then 2 -> valid with no seq_err.
- Sequence error: 3 then 5 -> seq_err pulse, seq_err_cnt=1.
  - Then blank, then 9 -> no error.
  - Then force 300 errors -> seq_err_cnt saturates at 255.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and decode result bundle.
// Patterns are {g,f,e,d,c,b,a}, bit i = segment i lit.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG7_BLANK = 7'h00;

    // Entry 15 is listed first so that SEG7_HEX[d] is the glyph of d.
    localparam logic [15:0][6:0] SEG7_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       valid;
        logic       is_blank;
        logic [3:0] digit;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex digit decoder.
// Patterns outside the glyph table and blank leave valid low.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg7_dec_t  dec
);

    always_comb begin
        dec = '0;
        dec.is_blank = (pattern == SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG7_HEX[i]) begin
                dec.valid = 1'b1;
                dec.digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_bar_reader.sv
// Monitors seven RGB segment bars, decodes stable patterns to hex digits
// and flags digits that break the +1 mod 16 count sequence.
module seg7_bar_reader
    import seg7_pkg::*;
#(
    parameter int         STABLE_CYCLES = 4,
    parameter logic [7:0] LIT_THRESH    = 8'h80,
    parameter int         ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          bar_0,
    input  logic [23:0]          bar_1,
    input  logic [23:0]          bar_2,
    input  logic [23:0]          bar_3,
    input  logic [23:0]          bar_4,
    input  logic [23:0]          bar_5,
    input  logic [23:0]          bar_6,
    output logic [6:0]           segs,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 blank,
    output logic                 pattern_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] seq_err_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0][23:0] bars;
    logic [6:0]       lit_d;
    logic [6:0]       seg_q;
    logic [6:0]       seg_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_q;
    logic             acc_eff;
    logic             acc_d;
    logic             accept;
    logic             same;
    logic             has_prev;
    logic [3:0]       prev_digit;
    seg7_dec_t        dec;

    assign bars[SEG_A] = bar_0;
    assign bars[SEG_B] = bar_1;
    assign bars[SEG_C] = bar_2;
    assign bars[SEG_D] = bar_3;
    assign bars[SEG_E] = bar_4;
    assign bars[SEG_F] = bar_5;
    assign bars[SEG_G] = bar_6;

    always_comb begin
        lit_d = '0;
        for (int i = 0; i < 7; i++) begin
            lit_d[i] = (bars[i][23:16] >= LIT_THRESH)
                     | (bars[i][15:8]  >= LIT_THRESH)
                     | (bars[i][7:0]   >= LIT_THRESH);
        end
    end

    // A changed pattern restarts the episode, so it may accept afresh.
    always_comb begin
        same    = (seg_q == seg_prev_q);
        cnt_d   = CNT_W'(1);
        acc_eff = 1'b0;
        if (same) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            acc_eff = acc_q;
        end
        accept = (cnt_d == CNT_MAX) && !acc_eff;
        acc_d  = acc_eff | accept;
    end

    seg7_decode u_decode (
        .pattern (seg_q),
        .dec     (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q       <= '0;
            seg_prev_q  <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            has_prev    <= 1'b0;
            prev_digit  <= '0;
            segs        <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            seq_err_cnt <= '0;
        end else begin
            seg_q       <= lit_d;
            seg_prev_q  <= seg_q;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            if (accept) begin
                segs <= seg_q;
                if (dec.valid) begin
                    digit       <= dec.digit;
                    digit_valid <= 1'b1;
                    blank       <= 1'b0;
                    prev_digit  <= dec.digit;
                    has_prev    <= 1'b1;
                    if (has_prev && dec.digit != prev_digit + 4'd1) begin
                        seq_err <= 1'b1;
                        if (seq_err_cnt != '1) begin
                            seq_err_cnt <= seq_err_cnt + 1'b1;
                        end
                    end
                end else if (dec.is_blank) begin
                    blank    <= 1'b1;
                    has_prev <= 1'b0;
                end else begin
                    pattern_err <= 1'b1;
                    has_prev    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_bar_reader.sv
// Directed-vector bench for seg7_bar_reader: pattern table plus
// hand-written glitch, saturation and reset-mid-settle sequences.
module tb_seg7_bar_reader;

    logic        clk;
    logic        rst;
    logic [23:0] bv [7];
    logic [6:0]  segs;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        blank;
    logic        pattern_err;
    logic        seq_err;
    logic [7:0]  seq_err_cnt;

    int checks;
    int failures;
    int n_valid;
    int n_perr;
    int n_serr;
    int n_eight;
    int n_bad;
    logic [3:0] last_logged;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [23:0] LIT_C [4] = '{
        24'h80_00_00, 24'h00_80_00, 24'h00_00_80, 24'hFF_FF_FF
    };
    localparam logic [23:0] DARK_C [4] = '{
        24'h7F_7F_7F, 24'h00_00_00, 24'h7F_00_7F, 24'h00_7F_00
    };

    typedef struct {
        logic [6:0] pat;
        int         hold;
        int         nv;
        logic [3:0] dig;
        int         np;
        int         ns;
        logic       blk;
        int         cnt;
    } vec_t;

    vec_t tbl [$];

    seg7_bar_reader dut (
        .clk         (clk),
        .rst         (rst),
        .bar_0       (bv[0]),
        .bar_1       (bv[1]),
        .bar_2       (bv[2]),
        .bar_3       (bv[3]),
        .bar_4       (bv[4]),
        .bar_5       (bv[5]),
        .bar_6       (bv[6]),
        .segs        (segs),
        .digit       (digit),
        .digit_valid (digit_valid),
        .blank       (blank),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .seq_err_cnt (seq_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse log; seq_err must never appear without digit_valid.
    always @(negedge clk) begin
        if (rst) begin
            if (digit_valid) begin
                n_valid++;
                last_logged = digit;
                if (digit == 4'd8) n_eight++;
            end
            if (pattern_err) n_perr++;
            if (seq_err) n_serr++;
            if (seq_err && !digit_valid) n_bad++;
            if (pattern_err && digit_valid) n_bad++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_pat(input logic [6:0] p, input int var_i);
        for (int i = 0; i < 7; i++) begin
            bv[i] = p[i] ? LIT_C[(i + var_i) % 4] : DARK_C[(i + var_i) % 4];
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] pat, input int nv,
                                input logic [3:0] dig, input int np,
                                input int ns, input logic blk,
                                input int cnt);
        vec_t v;
        v.pat = pat; v.hold = 6; v.nv = nv; v.dig = dig;
        v.np = np; v.ns = ns; v.blk = blk; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int v0, p0, s0, e0, exp_cnt;
        checks = 0; failures = 0;
        n_valid = 0; n_perr = 0; n_serr = 0; n_eight = 0; n_bad = 0;
        last_logged = '0;

        tbl.push_back(mk(7'h00, 0, 4'd1, 0, 0, 1'b1, 0));
        for (int d = 0; d < 16; d++) begin
            tbl.push_back(mk(HEX[d], 1, 4'(d), 0, 0, 1'b0, 0));
        end
        tbl.push_back(mk(HEX[0], 1, 4'd0, 0, 0, 1'b0, 0));
        tbl.push_back(mk(7'h01,  0, 4'd0, 1, 0, 1'b0, 0));
        tbl.push_back(mk(HEX[2], 1, 4'd2, 0, 0, 1'b0, 0));
        tbl.push_back(mk(HEX[3], 1, 4'd3, 0, 0, 1'b0, 0));
        tbl.push_back(mk(HEX[5], 1, 4'd5, 0, 1, 1'b0, 1));
        tbl.push_back(mk(7'h00,  0, 4'd5, 0, 0, 1'b1, 1));
        tbl.push_back(mk(HEX[9], 1, 4'd9, 0, 0, 1'b0, 1));
        tbl.push_back(mk(7'h40,  0, 4'd9, 1, 0, 1'b0, 1));
        tbl.push_back(mk(HEX[0], 1, 4'd0, 0, 0, 1'b0, 1));

        rst = 1'b0;
        for (int i = 0; i < 7; i++) bv[i] = 24'($urandom);
        hold(3);
        chk("rst_segs", 32'(segs), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_valid", 32'(digit_valid), 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_perr", 32'(pattern_err), 0);
        chk("rst_serr", 32'(seq_err), 0);
        chk("rst_cnt", 32'(seq_err_cnt), 0);

        @(negedge clk);
        for (int i = 0; i < 7; i++) bv[i] = '0;
        bv[1] = 24'h00_7F_00;
        bv[2] = 24'h00_7F_00;
        rst = 1'b1;
        hold(6);
        chk("thr_dark_segs", 32'(segs), 0);
        chk("thr_dark_blank", 32'(blank), 1);
        chk("thr_dark_valid", 32'(n_valid), 0);
        chk("thr_dark_perr", 32'(n_perr), 0);

        bv[1] = 24'h00_80_00;
        bv[2] = 24'h00_80_00;
        hold(5);
        chk("thr_lit_valid", 32'(n_valid), 1);
        chk("thr_lit_digit", 32'(digit), 1);
        chk("thr_lit_segs", 32'(segs), 32'h06);
        chk("thr_lit_blank", 32'(blank), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            v0 = n_valid; p0 = n_perr; s0 = n_serr;
            set_pat(tbl[i].pat, i);
            hold(tbl[i].hold);
            chk($sformatf("v%0d_valid", i), 32'(n_valid - v0), 32'(tbl[i].nv));
            chk($sformatf("v%0d_perr", i), 32'(n_perr - p0), 32'(tbl[i].np));
            chk($sformatf("v%0d_serr", i), 32'(n_serr - s0), 32'(tbl[i].ns));
            chk($sformatf("v%0d_digit", i), 32'(digit), 32'(tbl[i].dig));
            chk($sformatf("v%0d_segs", i), 32'(segs), 32'(tbl[i].pat));
            chk($sformatf("v%0d_blank", i), 32'(blank), 32'(tbl[i].blk));
            chk($sformatf("v%0d_cnt", i), 32'(seq_err_cnt), 32'(tbl[i].cnt));
            if (tbl[i].nv != 0) begin
                chk($sformatf("v%0d_log", i), 32'(last_logged), 32'(tbl[i].dig));
            end
        end
        exp_cnt = 1;

        set_pat(7'h00, 1);
        hold(6);
        set_pat(HEX[3], 2);
        hold(6);
        chk("glitch_pre_digit", 32'(digit), 3);
        v0 = n_valid; s0 = n_serr; e0 = n_eight;
        set_pat(HEX[8], 3);
        hold(1);
        set_pat(HEX[3], 2);
        hold(8);
        chk("glitch_valid", 32'(n_valid - v0), 1);
        chk("glitch_no8", 32'(n_eight - e0), 0);
        chk("glitch_digit", 32'(digit), 3);
        chk("glitch_segs", 32'(segs), 32'h4F);
        chk("glitch_serr", 32'(n_serr - s0), 1);
        exp_cnt++;
        chk("glitch_cnt", 32'(seq_err_cnt), 32'(exp_cnt));

        s0 = n_serr;
        for (int i = 0; i < 300; i++) begin
            set_pat((i % 2 == 0) ? HEX[5] : HEX[3], i);
            hold(5);
        end
        chk("sat_pulses", 32'(n_serr - s0), 300);
        chk("sat_cnt", 32'(seq_err_cnt), 255);

        set_pat(HEX[6], 0);
        hold(2);
        @(negedge clk);
        rst = 1'b0;
        hold(2);
        chk("mid_rst_cnt", 32'(seq_err_cnt), 0);
        chk("mid_rst_digit", 32'(digit), 0);
        chk("mid_rst_segs", 32'(segs), 0);
        @(negedge clk);
        rst = 1'b1;
        v0 = n_valid; s0 = n_serr;
        hold(6);
        chk("post_rst_valid", 32'(n_valid - v0), 1);
        chk("post_rst_digit", 32'(digit), 6);
        chk("post_rst_serr", 32'(n_serr - s0), 0);
        chk("post_rst_cnt", 32'(seq_err_cnt), 0);

        chk("pulse_consistency", 32'(n_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
